// File: rtl/hex_shift_sched.sv
// hex_shift_sched
//   Arbiter and strobe generator for the 8-digit shift-register
//   seven-segment display. Two requesters share the display:
//     A : single-nibble pushes (e.g. keypad)
//     W : 32-bit word loads, shifted out most significant nibble first
//   Each nibble is presented on `i` with `shift` high for SETUP_CYCLES,
//   then `shift` is held low for PULSE_CYCLES (the display captures on the
//   falling edge), then high again for PULSE_CYCLES.
//
// Ports
//   clk     in   1   system clock, rising-edge
//   reset   in   1   asynchronous active-high reset
//   req_a   in   1   requester A level request, held until gnt_a
//   nib_a   in   4   A nibble, sampled in the gnt_a cycle
//   gnt_a   out  1   one-cycle grant to A
//   req_w   in   1   requester W level request, held until gnt_w
//   word_w  in  32   W word, sampled in the gnt_w cycle
//   gnt_w   out  1   one-cycle grant to W
//   busy    out  1   transaction in progress
//   done    out  1   pulse on the last cycle of a transaction
//   shift   out  1   registered display strobe, idles high
//   i       out  4   registered nibble to the display
module hex_shift_sched #(
    parameter int SETUP_CYCLES = 1,
    parameter int PULSE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_a,
    input  logic [3:0]  nib_a,
    output logic        gnt_a,
    input  logic        req_w,
    input  logic [31:0] word_w,
    output logic        gnt_w,
    output logic        busy,
    output logic        done,
    output logic        shift,
    output logic [3:0]  i
);

    localparam int MAXC = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        LOW   = 2'd2,
        HIGH  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;      // cycles left in the current state, minus one
    logic [2:0]      idx_q, idx_d;      // nibbles still to send after the current one
    logic [27:0]     rest_q, rest_d;    // queued nibbles, next one in [27:24]
    logic            last_w_q, last_w_d; // round-robin pointer: 1 = W served last
    logic            gnt_a_q, gnt_a_d;
    logic            gnt_w_q, gnt_w_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            shift_q, shift_d;
    logic [3:0]      i_q, i_d;
    logic            arb;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        rest_d   = rest_q;
        last_w_d = last_w_q;
        i_d      = i_q;
        gnt_a_d  = 1'b0;
        gnt_w_d  = 1'b0;
        arb      = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The cycle carrying a grant is the cycle the data is sampled.
                if (gnt_a_q || gnt_w_q) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LOAD;
                    if (gnt_w_q) begin
                        i_d    = word_w[31:28];
                        rest_d = word_w[27:0];
                        idx_d  = 3'd7;
                    end else begin
                        i_d    = nib_a;
                        rest_d = '0;
                        idx_d  = 3'd0;
                    end
                end else begin
                    arb = 1'b1;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = LOW;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            LOW: begin
                if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = PULSE_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HIGH: begin
                if (cnt_q == '0) begin
                    if (idx_q != 3'd0) begin
                        state_d = SETUP;
                        cnt_d   = SETUP_LOAD;
                        idx_d   = idx_q - 3'd1;
                        i_d     = rest_q[27:24];
                        rest_d  = {rest_q[23:0], 4'h0};
                    end else begin
                        // Arbitrate on the way back to IDLE so the next grant
                        // lands in the very first IDLE cycle.
                        state_d = IDLE;
                        arb     = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (arb) begin
            if (req_a && (!req_w || last_w_q)) begin
                gnt_a_d  = 1'b1;
                last_w_d = 1'b0;
            end else if (req_w) begin
                gnt_w_d  = 1'b1;
                last_w_d = 1'b1;
            end
        end

        // Outputs are a registered view of the next state.
        busy_d  = (state_d != IDLE);
        shift_d = (state_d != LOW);
        done_d  = (state_d == HIGH) && (cnt_d == '0) && (idx_d == 3'd0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= 3'd0;
            last_w_q <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_w_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            shift_q  <= 1'b1;
            i_q      <= 4'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            last_w_q <= last_w_d;
            gnt_a_q  <= gnt_a_d;
            gnt_w_q  <= gnt_w_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            shift_q  <= shift_d;
            i_q      <= i_d;
        end
    end

    // Nibble queue is pure data; it is always reloaded before use.
    always_ff @(posedge clk) begin
        rest_q <= rest_d;
    end

    assign gnt_a = gnt_a_q;
    assign gnt_w = gnt_w_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign shift = shift_q;
    assign i     = i_q;

endmodule

// File: tb/tb_hex_shift_sched.sv
module tb_hex_shift_sched;

    localparam int S    = 1;
    localparam int P    = 2;
    localparam int N    = S + 2 * P;
    localparam int WMAX = 256;
    localparam int BIG  = 1000000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_a = 1'b0;
    logic [3:0]  nib_a = 4'h0;
    logic        gnt_a;
    logic        req_w = 1'b0;
    logic [31:0] word_w = 32'h0;
    logic        gnt_w;
    logic        busy;
    logic        done;
    logic        shift;
    logic [3:0]  i;

    int tests = 0;
    int fails = 0;

    hex_shift_sched #(.SETUP_CYCLES(S), .PULSE_CYCLES(P)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .nib_a(nib_a), .gnt_a(gnt_a),
        .req_w(req_w), .word_w(word_w), .gnt_w(gnt_w),
        .busy(busy), .done(done), .shift(shift), .i(i)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Display model: captures i on each falling edge of shift.
    logic [3:0] fall_log [4096];
    int falls_obs = 0;
    always @(negedge shift) begin
        if (falls_obs < 4096) fall_log[falls_obs] = i;
        falls_obs++;
    end

    function automatic logic [31:0] obs_disp(input int base);
        logic [31:0] d;
        d = '0;
        for (int k = base; k < falls_obs && k < 4096; k++) d = {d[27:0], fall_log[k]};
        return d;
    endfunction

    // Request schedule: arrival = cycle the request is first present,
    // -1 = raised again right after the previous item of that requester.
    logic [3:0]  a_nib [8];
    int          a_arr [8];
    int          a_cnt;
    logic [31:0] w_word [4];
    int          w_arr [4];
    int          w_cnt;

    logic [8:0]  exp_v [WMAX];   // {gnt_a,gnt_w,busy,done,shift,i}
    logic [8:0]  obs_v [WMAX];
    logic [31:0] m_disp;
    int          m_falls;
    int          m_end;

    task automatic clear_sched();
        a_cnt = 0;
        w_cnt = 0;
    endtask

    // Transaction-level reference: each grant lands at the later of "display
    // free" and "the cycle after the request appeared"; ties go to whoever was
    // not served last; a transaction is n slots of N cycles after the grant.
    task automatic model_build(input logic [3:0] i0);
        logic [4:0]  ctl [WMAX];
        int          ei  [WMAX];
        logic [3:0]  nibs [8];
        logic [31:0] wd;
        logic [3:0]  cur;
        int free, ia, iw, pta, ptw, ra, ca, cw, t, nn, c;
        logic lastw, pick_a;
        for (int k = 0; k < WMAX; k++) begin ctl[k] = 5'b00001; ei[k] = -1; end
        free = 1; lastw = 1'b1; ia = 0; iw = 0; pta = -10; ptw = -10;
        m_disp = '0; m_falls = 0; m_end = 0;
        while (ia < a_cnt || iw < w_cnt) begin
            ca = BIG; cw = BIG;
            if (ia < a_cnt) begin
                ra = (a_arr[ia] < 0) ? pta + 1 : a_arr[ia];
                ca = (free > ra + 1) ? free : ra + 1;
            end
            if (iw < w_cnt) begin
                ra = (w_arr[iw] < 0) ? ptw + 1 : w_arr[iw];
                cw = (free > ra + 1) ? free : ra + 1;
            end
            pick_a = (ca < cw) || (ca == cw && lastw);
            t = pick_a ? ca : cw;
            if (pick_a) begin
                nn = 1; nibs[0] = a_nib[ia]; ia++; pta = t; lastw = 1'b0;
                if (t < WMAX) ctl[t][4] = 1'b1;
            end else begin
                nn = 8; wd = w_word[iw]; iw++; ptw = t; lastw = 1'b1;
                for (int k = 0; k < 8; k++) nibs[k] = wd[31-4*k -: 4];
                if (t < WMAX) ctl[t][3] = 1'b1;
            end
            for (int k = 0; k < nn; k++) begin
                for (int o = 0; o < N; o++) begin
                    c = t + 1 + k * N + o;
                    if (c < WMAX) begin
                        ei[c]  = int'(nibs[k]);
                        ctl[c] = {2'b00, 1'b1, (k == nn - 1 && o == N - 1), !(o >= S && o < S + P)};
                    end
                end
                m_disp = {m_disp[27:0], nibs[k]};
                m_falls++;
            end
            free  = t + nn * N + 1;
            m_end = free;
        end
        cur = i0;
        for (int k = 0; k < WMAX; k++) begin
            if (ei[k] >= 0) cur = 4'(ei[k]);
            exp_v[k] = {ctl[k], cur};
        end
    endtask

    // Requesters: raise per schedule, hold until grant, move to the next item
    // the cycle after the grant (data stays stable through the grant cycle).
    task automatic run_window(input int n);
        int ia, iw, pa, pw, ar;
        logic pga, pgw;
        ia = 0; iw = 0; pa = -10; pw = -10; pga = 1'b0; pgw = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            obs_v[c] = {gnt_a, gnt_w, busy, done, shift, i};
            if (pga) begin ia++; pa = c - 1; end
            if (pgw) begin iw++; pw = c - 1; end
            pga = gnt_a; pgw = gnt_w;
            req_a = 1'b0; req_w = 1'b0;
            if (ia < a_cnt) begin
                ar = (a_arr[ia] < 0) ? pa + 1 : a_arr[ia];
                nib_a = a_nib[ia];
                req_a = (ar <= c);
            end
            if (iw < w_cnt) begin
                ar = (w_arr[iw] < 0) ? pw + 1 : w_arr[iw];
                word_w = w_word[iw];
                req_w = (ar <= c);
            end
        end
        req_a = 1'b0; req_w = 1'b0;
    endtask

    task automatic do_reset();
        req_a = 1'b0; req_w = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int fb, n;
        do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++; if (shift !== 1'b1) begin fails++; $display("FAIL reset_shift got %b want 1", shift); end
        tests++; if (i !== 4'h0) begin fails++; $display("FAIL reset_i got %h want 0", i); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if ({gnt_a, gnt_w} !== 2'b00) begin fails++; $display("FAIL reset_gnt got %b want 00", {gnt_a, gnt_w}); end
        @(negedge clk);
        reset = 1'b0;
        clear_sched();
        model_build(4'h0);
        fb = falls_obs;
        n = 100;
        run_window(n);
        for (int c = 0; c < n; c++) begin
            tests++;
            if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL idle cyc %0d got %b want %b", c, obs_v[c], exp_v[c]); end
        end
        tests++; if (falls_obs - fb !== 0) begin fails++; $display("FAIL idle_edges got %0d want 0", falls_obs - fb); end
    endtask

    task automatic test_single_a();
        int fb, n;
        do_reset();
        clear_sched();
        a_nib[0] = 4'h5; a_arr[0] = 0; a_cnt = 1;
        model_build(4'h0);
        fb = falls_obs;
        n = m_end + 3;
        run_window(n);
        for (int c = 0; c < n; c++) begin
            tests++;
            if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL single_a cyc %0d got %b want %b", c, obs_v[c], exp_v[c]); end
        end
        tests++; if (falls_obs - fb !== 1) begin fails++; $display("FAIL single_a_edges got %0d want 1", falls_obs - fb); end
        tests++; if (obs_disp(fb) !== 32'h5) begin fails++; $display("FAIL single_a_disp got %h want 00000005", obs_disp(fb)); end
    endtask

    task automatic test_word();
        int fb, n;
        do_reset();
        clear_sched();
        w_word[0] = 32'h1234ABCD; w_arr[0] = 0; w_cnt = 1;
        model_build(4'h0);
        fb = falls_obs;
        n = m_end + 3;
        run_window(n);
        for (int c = 0; c < n; c++) begin
            tests++;
            if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL word cyc %0d got %b want %b", c, obs_v[c], exp_v[c]); end
        end
        tests++; if (falls_obs - fb !== 8) begin fails++; $display("FAIL word_edges got %0d want 8", falls_obs - fb); end
        tests++; if (obs_disp(fb) !== 32'h1234ABCD) begin fails++; $display("FAIL word_disp got %h want 1234abcd", obs_disp(fb)); end
    endtask

    task automatic test_tie_alternate();
        int fb, n;
        do_reset();
        clear_sched();
        a_nib[0] = 4'($urandom); a_arr[0] = 0;
        a_nib[1] = 4'($urandom); a_arr[1] = -1; a_cnt = 2;
        w_word[0] = $urandom; w_arr[0] = 0;
        w_word[1] = $urandom; w_arr[1] = -1; w_cnt = 2;
        model_build(4'h0);
        fb = falls_obs;
        n = m_end + 3;
        run_window(n);
        for (int c = 0; c < n; c++) begin
            tests++;
            if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL tie cyc %0d got %b want %b", c, obs_v[c], exp_v[c]); end
        end
        tests++; if (falls_obs - fb !== m_falls) begin fails++; $display("FAIL tie_edges got %0d want %0d", falls_obs - fb, m_falls); end
        tests++; if (obs_disp(fb) !== m_disp) begin fails++; $display("FAIL tie_disp got %h want %h", obs_disp(fb), m_disp); end
    endtask

    task automatic test_a_during_w();
        int fb, n;
        do_reset();
        clear_sched();
        w_word[0] = $urandom; w_arr[0] = 0; w_cnt = 1;
        a_nib[0] = 4'($urandom); a_arr[0] = int'($urandom_range(3, 38)); a_cnt = 1;
        model_build(4'h0);
        fb = falls_obs;
        n = m_end + 3;
        run_window(n);
        for (int c = 0; c < n; c++) begin
            tests++;
            if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL a_during_w cyc %0d got %b want %b", c, obs_v[c], exp_v[c]); end
        end
        tests++; if (obs_disp(fb) !== m_disp) begin fails++; $display("FAIL a_during_w_disp got %h want %h", obs_disp(fb), m_disp); end
    endtask

    task automatic test_reset_mid_word();
        int fb, n;
        logic got;
        do_reset();
        fb = falls_obs;
        word_w = $urandom;
        req_w = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (gnt_w) begin got = 1'b1; break; end
        end
        req_w = 1'b0;
        tests++;
        if (!got) begin
            fails++; $display("FAIL midreset_grant got none want gnt_w within 10 cycles");
        end else begin
            repeat (17) @(negedge clk);
            tests++; if (shift !== 1'b0) begin fails++; $display("FAIL midreset_low got %b want 0", shift); end
            tests++; if (falls_obs - fb !== 4) begin fails++; $display("FAIL midreset_edges got %0d want 4", falls_obs - fb); end
            #1 reset = 1'b1;
            #1;
            tests++; if (shift !== 1'b1) begin fails++; $display("FAIL midreset_shift got %b want 1", shift); end
            tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midreset_busy got %b want 0", busy); end
            tests++; if (done !== 1'b0) begin fails++; $display("FAIL midreset_done got %b want 0", done); end
        end
        @(negedge clk);
        reset = 1'b0;
        clear_sched();
        a_nib[0] = 4'hF; a_arr[0] = 0; a_cnt = 1;
        model_build(4'h0);
        fb = falls_obs;
        n = m_end + 3;
        run_window(n);
        for (int c = 0; c < n; c++) begin
            tests++;
            if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL after_reset cyc %0d got %b want %b", c, obs_v[c], exp_v[c]); end
        end
        tests++; if (falls_obs - fb !== 1) begin fails++; $display("FAIL after_reset_edges got %0d want 1", falls_obs - fb); end
        tests++; if (obs_disp(fb) !== 32'hF) begin fails++; $display("FAIL after_reset_disp got %h want 0000000f", obs_disp(fb)); end
    endtask

    task automatic test_random();
        int fb, n;
        for (int it = 0; it < 6; it++) begin
            do_reset();
            clear_sched();
            a_cnt = int'($urandom_range(0, 3));
            w_cnt = int'($urandom_range(0, 2));
            if (a_cnt == 0 && w_cnt == 0) a_cnt = 1;
            for (int k = 0; k < a_cnt; k++) begin
                a_nib[k] = 4'($urandom);
                a_arr[k] = (k == 0) ? int'($urandom_range(0, 20))
                         : ($urandom_range(0, 1) != 0 ? -1 : int'($urandom_range(0, 60)));
            end
            for (int k = 0; k < w_cnt; k++) begin
                w_word[k] = $urandom;
                w_arr[k] = (k == 0) ? int'($urandom_range(0, 20))
                         : ($urandom_range(0, 1) != 0 ? -1 : int'($urandom_range(0, 60)));
            end
            model_build(4'h0);
            fb = falls_obs;
            n = (m_end + 3 < WMAX) ? m_end + 3 : WMAX;
            run_window(n);
            for (int c = 0; c < n; c++) begin
                tests++;
                if (obs_v[c] !== exp_v[c]) begin fails++; $display("FAIL random%0d cyc %0d got %b want %b", it, c, obs_v[c], exp_v[c]); end
            end
            tests++; if (falls_obs - fb !== m_falls) begin fails++; $display("FAIL random%0d_edges got %0d want %0d", it, falls_obs - fb, m_falls); end
            tests++; if (obs_disp(fb) !== m_disp) begin fails++; $display("FAIL random%0d_disp got %h want %h", it, obs_disp(fb), m_disp); end
        end
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_word();
        test_tie_alternate();
        test_a_during_w();
        test_reset_mid_word();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hex_shift_sched.md
Name: hex_shift_sched

Overview:
- Controller and arbiter for the 8-digit shift-register seven-segment display (`shift` strobe plus 4-bit nibble `i`; display captures on the negedge of `shift`).
- Shares the display between two requesters:
  - A: single-nibble pushes, e.g. keypad.
  - W: 32-bit word loads, 8 nibbles MSN first.
- Generates glitch-free, timed shift strobes with `i` held stable around each falling edge.
- Sits between the lab's input logic and the display shifter.

Parameters:
- SETUP_CYCLES, 1, cycles `i` is driven with `shift`=1 before each falling edge; legal range >=1.
- PULSE_CYCLES, 2, cycles `shift` stays low, and then cycles it stays high after each nibble; legal range >=1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_a  input  1  requester A wants to push one nibble; level, held until gnt_a.
- nib_a  input  4  nibble from A; sampled in the gnt_a cycle.
- gnt_a  output  1  one-cycle grant to A.
- req_w  input  1  requester W wants to load a full word; level, held until gnt_w.
- word_w  input  32  word from W; sampled in the gnt_w cycle.
- gnt_w  output  1  one-cycle grant to W.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse on the last cycle of a transaction.
- shift  output  1  registered strobe to the display; idles high.
- i  output  4  registered nibble to the display.

Behaviour:
- Reset (async, immediate) drives these outputs:
  - shift=1, i=0, gnt_a=0, gnt_w=0, busy=0, done=0.
  - FSM goes to IDLE; round-robin pointer set to last_served=W, so A wins the first tie.
- Reset never produces a falling edge on shift. Reset asserted during LOW raises shift, which is harmless. The partially shifted word is abandoned; display content is undefined for the verifier.
- All outputs are registered; there are no combinational paths from inputs to shift or i.
- States: IDLE, SETUP, LOW, HIGH. A down-counter times each state; a 3-bit nibble index tracks position within a word.
- IDLE:
  - If any request is pending, assert the grant for exactly one cycle T and latch the data.
  - Next state is SETUP with nibble count 1 (A) or 8 (W).
  - Grants are issued only from IDLE; requests arriving while busy wait.
- Arbitration on simultaneous req_a and req_w in IDLE:
  - Grant the requester not served last.
  - A single requester is granted regardless of the pointer.
  - The pointer updates on every grant.
- SETUP: i = current nibble, shift=1, for SETUP_CYCLES cycles, then LOW.
- LOW: shift=0 for PULSE_CYCLES cycles; i unchanged. The falling edge appears in the first LOW cycle.
- HIGH: shift=1 for PULSE_CYCLES cycles; i unchanged. At the end of HIGH:
  - If nibbles remain, go to SETUP with the next nibble.
  - Otherwise go to IDLE.
- Word order: word_w[31:28] first, through word_w[3:0] last. After 8 shifts, display digit 7 shows [31:28] and digit 0 shows [3:0].
- Timing, with N = SETUP_CYCLES + 2*PULSE_CYCLES (5 at defaults), grant in cycle T:
  - busy=1 in cycles T+1 through T+n*N, where n is the nibble count.
  - done=1 only in cycle T+n*N, the last HIGH cycle.
  - IDLE at T+n*N+1; the earliest next grant is in that cycle.
  - Nibble k (0-based) falling edge occurs at T+1+SETUP_CYCLES+k*N.
- At defaults:
  - A transaction is 5 busy cycles.
  - A W transaction is 40 busy cycles.
- i keeps its last value in IDLE.
- Requests dropped before grant are simply not served; no error reported.

Test Plan:
- Reset assert mid-idle, release: shift=1, i=0, busy=0, all grants and done 0. With no requests, no shift edge occurs over 100 cycles.
- req_a with nib_a=0x5, grant at T: gnt_a high only at T. i=5 from T+1. shift low T+2..T+3, high again T+4. done at T+5, busy T+1..T+5. Display model digit0 = 5.
- req_w with word_w=0x1234ABCD: exactly 8 falling edges, spaced 5 cycles, first at T+2. i sequence 1,2,3,4,A,B,C,D. done at T+40. Display model digits 7..0 read 1 2 3 4 A B C D.
- req_a and req_w both high from reset release:
  - A granted first, W granted at the first IDLE cycle after A's done (T+6).
  - Repeat with both held: grants alternate A,W,A,W.
- req_a raised during a W transaction: no gnt_a until the cycle after W's done. i is unchanged throughout each LOW phase; the checker samples i at every shift negedge.
- Async reset asserted during the 4th nibble's LOW phase: shift returns to 1 without a clock edge and busy drops. A subsequent req_a=0xF completes normally with a single falling edge.
